// File: rtl/cache_controller_fsm_if.sv
// Signal bundle between cache_controller_fsm and its CPU / tag-array / ACE
// neighbours. The optional ace_timeout line exists only when
// CACHE_CTRL_TIMEOUT_EN is defined.
// master: controller view. slave: environment view.
interface cache_controller_fsm_if;
  logic       cache_hit;
  logic       cache_miss;
  logic [2:0] line_state;
  logic [1:0] cpu_request;
  logic       ace_ready;
  logic       read_req;
  logic       write_req;
  logic       invalid_req;
  logic       write_from_cpu;
  logic       write_from_interconnect;
  logic [2:0] new_state;
  logic       state_sel;
  logic       cache_complete;
  logic       cache_ready;
`ifdef CACHE_CTRL_TIMEOUT_EN
  logic       ace_timeout;
`endif

  modport master (
    input  cache_hit, cache_miss, line_state, cpu_request, ace_ready,
`ifdef CACHE_CTRL_TIMEOUT_EN
    output ace_timeout,
`endif
    output read_req, write_req, invalid_req, write_from_cpu,
    output write_from_interconnect, new_state, state_sel,
    output cache_complete, cache_ready
  );

  modport slave (
    output cache_hit, cache_miss, line_state, cpu_request, ace_ready,
`ifdef CACHE_CTRL_TIMEOUT_EN
    input  ace_timeout,
`endif
    input  read_req, write_req, invalid_req, write_from_cpu,
    input  write_from_interconnect, new_state, state_sel,
    input  cache_complete, cache_ready
  );
endinterface

// File: rtl/cache_controller_fsm.sv
// Per-line control FSM for a write-back L1 data cache.
// Decodes CPU read/write requests against tag lookup results and the line's
// coherence state, then sequences ACE write-back, fill and invalidate
// transactions and drives the data-path muxes and state-array update.
// Optional macro CACHE_CTRL_TIMEOUT_EN adds an ace_timeout output and aborts
// an ACE request that waits ACE_TIMEOUT-1 cycles without ace_ready.
module cache_controller_fsm #(
  parameter int unsigned ACE_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  cache_controller_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    INVALIDATE,
    UPDATE
  } state_t;

  localparam logic [2:0] LS_I = 3'b000;
  localparam logic [2:0] LS_M = 3'b001;
  localparam logic [2:0] LS_E = 3'b010;
  localparam logic [2:0] LS_O = 3'b011;
  localparam logic [2:0] LS_S = 3'b100;

  if (ACE_TIMEOUT < 2) begin : g_param_check
    $error("ACE_TIMEOUT must be at least 2");
  end

  state_t     state_q, state_d;
  logic       write_q;
  logic       timeout_hit;
  logic [2:0] ls;

  // State register and latch of the accepted request type
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !bus.cpu_request[1]) begin
        write_q <= bus.cpu_request[0];
      end
    end
  end

`ifdef CACHE_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(ACE_TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  assign waiting     = (state_q == WRITEBACK) || (state_q == FILL) ||
                       (state_q == INVALIDATE);
  assign timeout_hit = waiting && !bus.ace_ready &&
                       (wait_cnt == CNT_W'(ACE_TIMEOUT - 1));
  assign bus.ace_timeout = timeout_hit;

  // Wait counter: restarts on every state change, counts cycles an ACE request waits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and output decode
  always_comb begin
    state_d                     = state_q;
    bus.read_req                = 1'b0;
    bus.write_req               = 1'b0;
    bus.invalid_req             = 1'b0;
    bus.write_from_cpu          = 1'b0;
    bus.write_from_interconnect = 1'b0;
    bus.new_state               = LS_I;
    bus.state_sel               = 1'b0;
    bus.cache_complete          = 1'b0;
    bus.cache_ready             = 1'b0;
    // Encodings above SharedClean are reserved and behave as Invalid
    ls = (bus.line_state > LS_S) ? LS_I : bus.line_state;

    case (state_q)
      IDLE: begin
        bus.cache_ready = 1'b1;
        if (!bus.cpu_request[1]) begin
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (bus.cache_hit) begin
          if (!write_q) begin
            bus.cache_complete = 1'b1;
            state_d            = IDLE;
          end else if (ls == LS_E || ls == LS_M) begin
            state_d = UPDATE;
          end else if (ls == LS_S || ls == LS_O) begin
            state_d = INVALIDATE;
          end else begin
            // Write "hit" on an Invalid line has no usable data: fetch it
            state_d = FILL;
          end
        end else if (bus.cache_miss) begin
          state_d = (ls == LS_M || ls == LS_O) ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        bus.write_req = !timeout_hit;
        if (bus.ace_ready) begin
          bus.state_sel = 1'b1;
          bus.new_state = LS_I;
          state_d       = FILL;
        end else if (timeout_hit) begin
          bus.cache_complete = 1'b1;
          state_d            = IDLE;
        end
      end

      FILL: begin
        bus.read_req = !timeout_hit;
        if (bus.ace_ready) begin
          bus.write_from_interconnect = 1'b1;
          bus.state_sel               = 1'b1;
          bus.new_state               = LS_E;
          if (write_q) begin
            state_d = UPDATE;
          end else begin
            bus.cache_complete = 1'b1;
            state_d            = IDLE;
          end
        end else if (timeout_hit) begin
          bus.cache_complete = 1'b1;
          state_d            = IDLE;
        end
      end

      INVALIDATE: begin
        bus.invalid_req = !timeout_hit;
        if (bus.ace_ready) begin
          state_d = UPDATE;
        end else if (timeout_hit) begin
          bus.cache_complete = 1'b1;
          state_d            = IDLE;
        end
      end

      UPDATE: begin
        bus.write_from_cpu = 1'b1;
        bus.state_sel      = 1'b1;
        bus.new_state      = LS_M;
        bus.cache_complete = 1'b1;
        state_d            = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller_fsm.sv
// Self-checking bench for cache_controller_fsm (default build). Each
// transaction is expanded by a transaction-level model into a per-cycle list
// of driven inputs and expected outputs, then replayed against the DUT.
module tb_cache_controller_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_controller_fsm_if bus ();

  cache_controller_fsm #(.ACE_TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // {read_req, write_req, invalid_req, wr_cpu, wr_ic, new_state[2:0], state_sel, complete, ready}
  logic [10:0] obs;
  assign obs = {bus.read_req, bus.write_req, bus.invalid_req, bus.write_from_cpu,
                bus.write_from_interconnect, bus.new_state, bus.state_sel,
                bus.cache_complete, bus.cache_ready};

  localparam logic [10:0] EXP_IDLE = 11'b000_00_000_001;

  typedef struct {
    logic [1:0]  req;
    logic        hit;
    logic        miss;
    logic [2:0]  ls;
    logic        rdy;
    logic [10:0] exp;
  } cyc_t;

  cyc_t q[$];

  function automatic logic [10:0] ov(input logic rr, input logic wq, input logic ir,
                                     input logic wfc, input logic wfi, input logic [2:0] ns,
                                     input logic ss, input logic cc, input logic rd);
    return {rr, wq, ir, wfc, wfi, ns, ss, cc, rd};
  endfunction

  function automatic void push(input logic [1:0] req, input logic hit, input logic miss,
                               input logic [2:0] ls, input logic rdy, input logic [10:0] exp);
    cyc_t c;
    c.req = req; c.hit = hit; c.miss = miss; c.ls = ls; c.rdy = rdy; c.exp = exp;
    q.push_back(c);
  endfunction

  // Noise values for inputs the controller must ignore in a given cycle
  function automatic logic       n1();  return 1'($urandom);  endfunction
  function automatic logic [1:0] n2();  return 2'($urandom);  endfunction
  function automatic logic [2:0] n3();  return 3'($urandom);  endfunction

  // Transaction model: wr = write request; hm 1=hit, 2=miss, 3=both;
  // stall = LOOKUP cycles with neither hit nor miss; dw/df/di = wait cycles
  // before ace_ready for write-back / fill / invalidate; pre = idle cycles first.
  task automatic build_txn(input bit wr, input int hm, input logic [2:0] ls, input int stall,
                           input int dw, input int df, input int di, input int pre);
    logic [2:0] lsn;
    bit is_hit, dirty;
    q.delete();
    lsn    = (ls > 3'd4) ? 3'd0 : ls;
    is_hit = (hm != 2);
    dirty  = (lsn == 3'd1) || (lsn == 3'd3);
    for (int i = 0; i < pre; i++) push({1'b1, n1()}, n1(), n1(), n3(), n1(), EXP_IDLE);
    push({1'b0, wr}, n1(), n1(), n3(), n1(), EXP_IDLE);
    for (int i = 0; i < stall; i++) push(n2(), 1'b0, 1'b0, n3(), n1(), '0);
    push(n2(), hm != 2, hm != 1, ls, n1(),
         (is_hit && !wr) ? ov(0, 0, 0, 0, 0, 3'b000, 0, 1, 0) : 11'd0);
    if (is_hit && !wr) begin
      // done in lookup
    end else if (is_hit && (lsn == 3'd1 || lsn == 3'd2)) begin
      push(n2(), n1(), n1(), n3(), n1(), ov(0, 0, 0, 1, 0, 3'b001, 1, 1, 0));
    end else if (is_hit && (lsn == 3'd3 || lsn == 3'd4)) begin
      for (int i = 0; i < di; i++) push(n2(), n1(), n1(), n3(), 1'b0, ov(0, 0, 1, 0, 0, 3'b000, 0, 0, 0));
      push(n2(), n1(), n1(), n3(), 1'b1, ov(0, 0, 1, 0, 0, 3'b000, 0, 0, 0));
      push(n2(), n1(), n1(), n3(), n1(), ov(0, 0, 0, 1, 0, 3'b001, 1, 1, 0));
    end else begin
      if (!is_hit && dirty) begin
        for (int i = 0; i < dw; i++) push(n2(), n1(), n1(), n3(), 1'b0, ov(0, 1, 0, 0, 0, 3'b000, 0, 0, 0));
        push(n2(), n1(), n1(), n3(), 1'b1, ov(0, 1, 0, 0, 0, 3'b000, 1, 0, 0));
      end
      for (int i = 0; i < df; i++) push(n2(), n1(), n1(), n3(), 1'b0, ov(1, 0, 0, 0, 0, 3'b000, 0, 0, 0));
      push(n2(), n1(), n1(), n3(), 1'b1, ov(1, 0, 0, 0, 1, 3'b010, 1, !wr, 0));
      if (wr) push(n2(), n1(), n1(), n3(), n1(), ov(0, 0, 0, 1, 0, 3'b001, 1, 1, 0));
    end
    push({1'b1, n1()}, n1(), n1(), n3(), n1(), EXP_IDLE);
  endtask

  task automatic drive(input cyc_t c);
    @(posedge clk);
    #1;
    bus.cpu_request = c.req;
    bus.cache_hit   = c.hit;
    bus.cache_miss  = c.miss;
    bus.line_state  = c.ls;
    bus.ace_ready   = c.rdy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.cpu_request = 2'b10; bus.cache_hit = 1'b1; bus.cache_miss = 1'b1;
    bus.line_state = 3'b001; bus.ace_ready = 1'b1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (obs !== EXP_IDLE) begin
      errors++; $display("FAIL reset_held: got %b expected %b", obs, EXP_IDLE);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== EXP_IDLE) begin
      errors++; $display("FAIL reset_release: got %b expected %b", obs, EXP_IDLE);
    end
  endtask

  task automatic test_read_hit();
    build_txn(1'b0, 1, 3'b010, 0, 0, 0, 0, 0);
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (obs !== q[i].exp) begin
        errors++; $display("FAIL read_hit cyc%0d: got %b expected %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_write_hit_shared();
    build_txn(1'b1, 1, 3'b100, 0, 0, 0, 2, 1);
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (obs !== q[i].exp) begin
        errors++; $display("FAIL write_hit_shared cyc%0d: got %b expected %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_read_miss_dirty();
    build_txn(1'b0, 2, 3'b011, 0, 0, 0, 0, 0);
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (obs !== q[i].exp) begin
        errors++; $display("FAIL read_miss_dirty cyc%0d: got %b expected %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_write_miss_clean();
    build_txn(1'b1, 2, 3'b000, 0, 0, 0, 0, 0);
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (obs !== q[i].exp) begin
        errors++; $display("FAIL write_miss_clean cyc%0d: got %b expected %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_lookup_stall();
    // Neither hit nor miss holds LOOKUP; both high counts as a hit; 101 acts as Invalid
    build_txn(1'b0, 3, 3'b101, 3, 0, 0, 0, 0);
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (obs !== q[i].exp) begin
        errors++; $display("FAIL lookup_stall_rd cyc%0d: got %b expected %b", i, obs, q[i].exp);
      end
    end
    build_txn(1'b1, 3, 3'b010, 2, 0, 0, 0, 0);
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (obs !== q[i].exp) begin
        errors++; $display("FAIL lookup_stall_wr cyc%0d: got %b expected %b", i, obs, q[i].exp);
      end
    end
    build_txn(1'b0, 2, 3'b111, 1, 0, 2, 0, 0);
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (obs !== q[i].exp) begin
        errors++; $display("FAIL miss_reserved_state cyc%0d: got %b expected %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    build_txn(1'b1, 2, 3'b000, 0, 0, 5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(q[i]);
      checks++;
      if (obs !== q[i].exp) begin
        errors++; $display("FAIL reset_mid_pre cyc%0d: got %b expected %b", i, obs, q[i].exp);
      end
    end
    #2;
    bus.cpu_request = 2'b10;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== EXP_IDLE) begin
      errors++; $display("FAIL reset_mid_async: got %b expected %b", obs, EXP_IDLE);
    end
    @(negedge clk);
    reset = 1'b1;
    build_txn(1'b0, 1, 3'b001, 0, 0, 0, 0, 1);
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (obs !== q[i].exp) begin
        errors++; $display("FAIL reset_mid_recover cyc%0d: got %b expected %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_random();
    int completes = 0;
    bit wr;
    int hm;
    logic [2:0] ls;
    for (int t = 0; t < 200; t++) begin
      wr = 1'($urandom);
      hm = $urandom_range(1, 3);
      ls = 3'($urandom_range(0, 7));
      if (wr && hm != 2 && (ls == 3'd0 || ls > 3'd4)) ls = 3'($urandom_range(1, 4));
      build_txn(wr, hm, ls, $urandom_range(0, 2), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 2));
      foreach (q[i]) begin
        drive(q[i]);
        completes += int'(bus.cache_complete);
        checks++;
        if (obs !== q[i].exp) begin
          errors++; $display("FAIL random t%0d cyc%0d: got %b expected %b", t, i, obs, q[i].exp);
        end
        checks++;
        if ($countones({bus.read_req, bus.write_req, bus.invalid_req}) > 1) begin
          errors++; $display("FAIL random_onehot t%0d cyc%0d: got %b expected at most one ACE request",
                             t, i, {bus.read_req, bus.write_req, bus.invalid_req});
        end
      end
    end
    checks++;
    if (completes != 200) begin
      errors++; $display("FAIL random_complete_count: got %0d expected 200", completes);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit_shared();
    test_read_miss_dirty();
    test_write_miss_clean();
    test_lookup_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
